// File: rtl/frame_timing_counter.sv
// frame_timing_counter
//   Raster timing generator. Counts colour-plane samples within a pixel,
//   pixels within a line, lines within a field and fields within a frame.
//   Interlaced frames carry two fields. Line and field lengths come from
//   shadow copies of the totals, so changes on the inputs take effect at
//   the next frame boundary.
//
// Parameters
//   H_WIDTH           width of h_count / h_total
//   V_WIDTH           width of v_count / v_total_f0 / v_total_f1
//   SAMPLES_PER_PIXEL sequential samples per pixel (1..4)
//   TOTALS_MINUS_ONE  1: totals are last indices, 0: totals are counts
//   FRAME_CNT_WIDTH   width of frame_count
//
// Ports
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   sclr               synchronous clear / preload from *_reset inputs
//   enable             cycle qualifier; nothing advances when low
//   interlaced         two fields per frame when high
//   h_total            samples-per-line total
//   v_total_f0/_f1     lines in field 0 / field 1
//   h_reset, v_reset,
//   field_reset        preload values applied on sclr
//   sample_ticks       sample index within the current pixel
//   start_of_pixel     high when sample_ticks is 0
//   h_count, v_count   registered position
//   field              registered current field
//   new_line/_field/_frame  combinational boundary strobes
//   frame_count        registered wrapping frame counter
module frame_timing_counter #(
    parameter int H_WIDTH           = 14,
    parameter int V_WIDTH           = 13,
    parameter int SAMPLES_PER_PIXEL = 1,
    parameter int TOTALS_MINUS_ONE  = 0,
    parameter int FRAME_CNT_WIDTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclr,
    input  logic                       enable,
    input  logic                       interlaced,
    input  logic [H_WIDTH-1:0]         h_total,
    input  logic [V_WIDTH-1:0]         v_total_f0,
    input  logic [V_WIDTH-1:0]         v_total_f1,
    input  logic [H_WIDTH-1:0]         h_reset,
    input  logic [V_WIDTH-1:0]         v_reset,
    input  logic                       field_reset,
    output logic [1:0]                 sample_ticks,
    output logic                       start_of_pixel,
    output logic [H_WIDTH-1:0]         h_count,
    output logic [V_WIDTH-1:0]         v_count,
    output logic                       field,
    output logic                       new_line,
    output logic                       new_field,
    output logic                       new_frame,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam logic [1:0] SPP_LAST = 2'(SAMPLES_PER_PIXEL - 1);
    localparam logic       SPP_ONE  = (SAMPLES_PER_PIXEL == 1);

    // Convert a supplied total into the last valid index. A count of zero
    // is treated as one so the last index never underflows.
    function automatic logic [H_WIDTH-1:0] h_last_of(input logic [H_WIDTH-1:0] total);
        if (TOTALS_MINUS_ONE != 0) return total;
        if (total == '0) return '0;
        return total - H_WIDTH'(1);
    endfunction

    function automatic logic [V_WIDTH-1:0] v_last_of(input logic [V_WIDTH-1:0] total);
        if (TOTALS_MINUS_ONE != 0) return total;
        if (total == '0) return '0;
        return total - V_WIDTH'(1);
    endfunction

    logic [H_WIDTH-1:0] h_last_shadow;
    logic [V_WIDTH-1:0] v_last_f0_shadow;
    logic [V_WIDTH-1:0] v_last_f1_shadow;
    logic               interlaced_shadow;
    logic               in_reset;
    logic               pixel_done;
    logic [V_WIDTH-1:0] v_last;

    // Strobes are held low while rst is asserted so a held-in-reset block
    // presents no boundaries.
    always_comb begin
        pixel_done = !rst && enable && (sample_ticks == SPP_LAST);
        v_last     = field ? v_last_f1_shadow : v_last_f0_shadow;
        new_line   = pixel_done && (h_count >= h_last_shadow);
        new_field  = new_line && (v_count >= v_last);
        new_frame  = new_field && (!interlaced_shadow || field);
    end

    assign start_of_pixel = (sample_ticks == 2'd0);

    // Remembers that rst has been seen since the last clock edge, so the
    // shadows are loaded while the block is held in reset without rst
    // itself appearing as a synchronous term.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) in_reset <= 1'b1;
        else     in_reset <= 1'b0;
    end

    // Shadow totals: captured on reset, on sclr and at each frame boundary.
    always_ff @(posedge clk) begin
        if (in_reset || sclr || new_frame) begin
            h_last_shadow     <= h_last_of(h_total);
            v_last_f0_shadow  <= v_last_of(v_total_f0);
            v_last_f1_shadow  <= v_last_of(v_total_f1);
            interlaced_shadow <= interlaced;
        end
    end

    // Position counters. The >= compares let a counter preloaded beyond
    // its total wrap at the next boundary instead of running to 2^width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_ticks <= 2'd0;
            h_count      <= '0;
            v_count      <= '0;
            field        <= 1'b0;
            frame_count  <= '0;
        end else if (sclr) begin
            sample_ticks <= 2'd0;
            // With one sample per pixel the clear cycle is itself a pixel
            // when enabled, so the preload lands one pixel further on.
            h_count      <= h_reset + H_WIDTH'(SPP_ONE && enable);
            v_count      <= v_reset;
            field        <= field_reset;
            frame_count  <= '0;
        end else if (enable) begin
            sample_ticks <= pixel_done ? 2'd0 : sample_ticks + 2'd1;
            if (new_line) begin
                h_count <= '0;
                if (new_field) begin
                    v_count <= '0;
                    field   <= interlaced_shadow ? !field : 1'b0;
                end else begin
                    v_count <= v_count + V_WIDTH'(1);
                end
                if (new_frame) frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
            end else if (pixel_done) begin
                h_count <= h_count + H_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_frame_timing_counter.sv
module tb_frame_timing_counter;

    localparam int HW = 8;
    localparam int VW = 6;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst, sclr, enable, interlaced, field_reset;
    logic [HW-1:0] h_total, h_reset;
    logic [VW-1:0] v_total_f0, v_total_f1, v_reset;

    logic [1:0]    st_a, st_b;
    logic          sop_a, sop_b, fld_a, fld_b;
    logic          nl_a, nl_b, nf_a, nf_b, nfr_a, nfr_b;
    logic [HW-1:0] h_a, h_b;
    logic [VW-1:0] v_a, v_b;
    logic [FW-1:0] fc_a, fc_b;

    always #5 clk = ~clk;

    // Instance a: one sample per pixel, totals as counts.
    frame_timing_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .SAMPLES_PER_PIXEL(1),
                           .TOTALS_MINUS_ONE(0), .FRAME_CNT_WIDTH(FW)) u_a (
        .clk(clk), .rst(rst), .sclr(sclr), .enable(enable), .interlaced(interlaced),
        .h_total(h_total), .v_total_f0(v_total_f0), .v_total_f1(v_total_f1),
        .h_reset(h_reset), .v_reset(v_reset), .field_reset(field_reset),
        .sample_ticks(st_a), .start_of_pixel(sop_a), .h_count(h_a), .v_count(v_a),
        .field(fld_a), .new_line(nl_a), .new_field(nf_a), .new_frame(nfr_a),
        .frame_count(fc_a));

    // Instance b: three samples per pixel, totals as last index.
    frame_timing_counter #(.H_WIDTH(HW), .V_WIDTH(VW), .SAMPLES_PER_PIXEL(3),
                           .TOTALS_MINUS_ONE(1), .FRAME_CNT_WIDTH(FW)) u_b (
        .clk(clk), .rst(rst), .sclr(sclr), .enable(enable), .interlaced(interlaced),
        .h_total(h_total), .v_total_f0(v_total_f0), .v_total_f1(v_total_f1),
        .h_reset(h_reset), .v_reset(v_reset), .field_reset(field_reset),
        .sample_ticks(st_b), .start_of_pixel(sop_b), .h_count(h_b), .v_count(v_b),
        .field(fld_b), .new_line(nl_b), .new_field(nf_b), .new_frame(nfr_b),
        .frame_count(fc_b));

    typedef struct {
        int st, sop, h, v, f, nl, nf, nfr, fc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: position as plain integers plus the frame
    // parameters latched at the start of the current frame.
    int spp_of [2] = '{1, 3};
    int tmo_of [2] = '{0, 1};
    int m_s [2], m_h [2], m_v [2], m_f [2], m_fc [2];
    int m_hl [2], m_vl0 [2], m_vl1 [2], m_il [2];

    function automatic int last_of(int total, int tmo);
        if (tmo != 0) return total;
        return (total == 0) ? 0 : total - 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    // Produce the expected outputs for the current cycle, then advance the
    // model across the coming clock edge.
    task automatic model_cycle(input int k, output exp_t e);
        int pd, nl, nf, nfr, vlast;
        if (rst) begin
            m_s[k] = 0; m_h[k] = 0; m_v[k] = 0; m_f[k] = 0; m_fc[k] = 0;
        end
        pd    = (!rst && enable && (m_s[k] == spp_of[k] - 1)) ? 1 : 0;
        nl    = (pd != 0 && m_h[k] >= m_hl[k]) ? 1 : 0;
        vlast = (m_f[k] != 0) ? m_vl1[k] : m_vl0[k];
        nf    = (nl != 0 && m_v[k] >= vlast) ? 1 : 0;
        nfr   = (nf != 0 && (m_il[k] == 0 || m_f[k] != 0)) ? 1 : 0;
        e = '{m_s[k], (m_s[k] == 0) ? 1 : 0, m_h[k], m_v[k], m_f[k], nl, nf, nfr, m_fc[k]};

        if (rst) begin
            m_s[k] = 0; m_h[k] = 0; m_v[k] = 0; m_f[k] = 0; m_fc[k] = 0;
        end else if (sclr) begin
            m_s[k]  = 0;
            m_h[k]  = (int'(h_reset) + ((spp_of[k] == 1) ? int'(enable) : 0)) % (1 << HW);
            m_v[k]  = int'(v_reset);
            m_f[k]  = int'(field_reset);
            m_fc[k] = 0;
        end else if (enable) begin
            m_s[k] = (pd != 0) ? 0 : m_s[k] + 1;
            if (nl != 0) begin
                m_h[k] = 0;
                if (nf != 0) begin
                    m_v[k] = 0;
                    m_f[k] = (m_il[k] != 0) ? 1 - m_f[k] : 0;
                end else begin
                    m_v[k] = (m_v[k] + 1) % (1 << VW);
                end
                if (nfr != 0) m_fc[k] = (m_fc[k] + 1) % (1 << FW);
            end else if (pd != 0) begin
                m_h[k] = (m_h[k] + 1) % (1 << HW);
            end
        end

        if (rst || sclr || nfr != 0) begin
            m_hl[k]  = last_of(int'(h_total), tmo_of[k]);
            m_vl0[k] = last_of(int'(v_total_f0), tmo_of[k]);
            m_vl1[k] = last_of(int'(v_total_f1), tmo_of[k]);
            m_il[k]  = int'(interlaced);
        end
    endtask

    // Issue the current inputs for one cycle: record expectations, then
    // move to 1 time unit after the next rising edge.
    task automatic step();
        exp_t e;
        model_cycle(0, e);
        q_a.push_back(e);
        model_cycle(1, e);
        q_b.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            chk("a_sample_ticks", 32'(st_a), e.st);
            chk("a_start_of_pixel", 32'(sop_a), e.sop);
            chk("a_h_count", 32'(h_a), e.h);
            chk("a_v_count", 32'(v_a), e.v);
            chk("a_field", 32'(fld_a), e.f);
            chk("a_new_line", 32'(nl_a), e.nl);
            chk("a_new_field", 32'(nf_a), e.nf);
            chk("a_new_frame", 32'(nfr_a), e.nfr);
            chk("a_frame_count", 32'(fc_a), e.fc);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("b_sample_ticks", 32'(st_b), e.st);
            chk("b_start_of_pixel", 32'(sop_b), e.sop);
            chk("b_h_count", 32'(h_b), e.h);
            chk("b_v_count", 32'(v_b), e.v);
            chk("b_field", 32'(fld_b), e.f);
            chk("b_new_line", 32'(nl_b), e.nl);
            chk("b_new_field", 32'(nf_b), e.nf);
            chk("b_new_frame", 32'(nfr_b), e.nfr);
            chk("b_frame_count", 32'(fc_b), e.fc);
        end
    end

    initial begin
        int prev_rst;
        rst = 1'b1; sclr = 1'b0; enable = 1'b0; interlaced = 1'b0;
        h_total = HW'(4); v_total_f0 = VW'(3); v_total_f1 = VW'(3);
        h_reset = '0; v_reset = '0; field_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step();

        // Progressive 4x3 frame, enable held high.
        rst = 1'b0; enable = 1'b1;
        repeat (36) step();
        chk("prog_frame_count_36", 32'(fc_a), 3);
        chk("prog_h_at_frame_edge", 32'(h_a), 0);

        // Line length change in the middle of a frame.
        repeat (5) step();
        h_total = HW'(6);
        repeat (40) step();

        // Interlaced: field 0 three lines, field 1 two lines.
        interlaced = 1'b1; v_total_f0 = VW'(3); v_total_f1 = VW'(2); h_total = HW'(2);
        sclr = 1'b1; step(); sclr = 1'b0;
        repeat (30) step();

        // Preload mid-line.
        repeat (2) step();
        h_reset = HW'(3); v_reset = VW'(2); field_reset = 1'b1;
        sclr = 1'b1; step(); sclr = 1'b0;
        chk("sclr_h_spp1", 32'(h_a), 4);
        chk("sclr_h_spp3", 32'(h_b), 3);
        chk("sclr_v", 32'(v_a), 2);
        chk("sclr_field", 32'(fld_a), 1);
        chk("sclr_frame_count", 32'(fc_b), 0);
        repeat (10) step();

        // Zero line total: every pixel ends a line on instance a.
        interlaced = 1'b0; h_total = '0; v_total_f0 = VW'(3);
        h_reset = '0; v_reset = '0; field_reset = 1'b0;
        sclr = 1'b1; step(); sclr = 1'b0;
        repeat (3) step();
        chk("hzero_new_line", 32'(nl_a), 1);
        repeat (10) step();

        // Asynchronous reset mid-frame.
        rst = 1'b1;
        #1;
        chk("arst_h", 32'(h_a), 0);
        chk("arst_v", 32'(v_b), 0);
        chk("arst_frame_count", 32'(fc_a), 0);
        chk("arst_sample_ticks", 32'(st_b), 0);
        step();
        rst = 1'b0;
        step();

        // Randomised traffic. Totals only change away from reset release so
        // the frame in flight keeps the totals latched at reset.
        prev_rst = 0;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 199) == 0);
            sclr   = ($urandom_range(0, 39) == 0);
            enable = ($urandom_range(0, 3) != 0);
            if (!rst && prev_rst == 0 && $urandom_range(0, 29) == 0) begin
                h_total    = HW'($urandom_range(0, 7));
                v_total_f0 = VW'($urandom_range(0, 4));
                v_total_f1 = VW'($urandom_range(0, 4));
                interlaced = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 9) == 0) begin
                h_reset     = ($urandom_range(0, 3) == 0) ? HW'($urandom_range(0, 255))
                                                          : HW'($urandom_range(0, 7));
                v_reset     = VW'($urandom_range(0, 7));
                field_reset = 1'($urandom_range(0, 1));
            end
            prev_rst = int'(rst);
            step();
        end
        rst = 1'b0; sclr = 1'b0; enable = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drain", 32'(q_a.size() + q_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
